// File: rtl/vend_pkg.sv
// vend_pkg: coin/change/item codes, controller states and the price table
package vend_pkg;
  localparam logic [1:0] COIN_NONE = 2'b00, COIN_5 = 2'b01, COIN_10 = 2'b10;
  localparam logic [1:0] CHG_NONE = 2'b00, CHG_5 = 2'b01, CHG_10 = 2'b10;
  localparam logic [7:0] ITEM_A1 = 8'hA1, ITEM_A2 = 8'hA2, ITEM_A3 = 8'hA3, ITEM_A4 = 8'hA4;
  typedef enum logic [1:0] {ST_IDLE, ST_DISPENSE, ST_PAYOUT} state_t;
  // price in 5-unit steps; 0 marks an unknown item
  function automatic logic [2:0] price_of(input logic [7:0] item);
    return item == ITEM_A1 ? 3'd1 : item == ITEM_A2 ? 3'd2 : item == ITEM_A3 ? 3'd3 : item == ITEM_A4 ? 3'd5 : 3'd0;
  endfunction
endpackage

// File: rtl/vend_change_seq.sv
// vend_change_seq: greedy payout step, one coin per cycle
// Ports: start enables a step, load is the credit before the step;
// change is the coin to emit, done flags nothing left to pay, rem is the credit after the coin.
module vend_change_seq
  import vend_pkg::*;
#(
  parameter int CREDIT_W = 4
) (
  input  logic                start,
  input  logic [CREDIT_W-1:0] load,
  output logic [1:0]          change,
  output logic                done,
  output logic [CREDIT_W-1:0] rem
);
  always_comb begin
    done = !start || load == '0;
    change = done ? CHG_NONE : load >= CREDIT_W'(2) ? CHG_10 : CHG_5;
    // change codes equal their value in 5-unit steps
    rem = load - CREDIT_W'(change);
  end
endmodule

// File: rtl/vend_txn_ctrl.sv
// vend_txn_ctrl: vending transaction controller (credit, selection, dispense handshake, payout)
// Ports: money/sel_item/cancel from the front panel; disp_req/disp_item/disp_ack dispenser handshake;
// item_out, change, credit, busy and the coin_rej/sel_err/disp_fail pulses are registered outputs.
module vend_txn_ctrl
  import vend_pkg::*;
#(
  parameter int CREDIT_W = 4,
  parameter int IDLE_TMO = 1000,
  parameter int DISP_TMO = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          money,
  input  logic [7:0]          sel_item,
  input  logic                cancel,
  input  logic                disp_ack,
  output logic                disp_req,
  output logic [7:0]          disp_item,
  output logic [7:0]          item_out,
  output logic [1:0]          change,
  output logic [CREDIT_W-1:0] credit,
  output logic                coin_rej,
  output logic                sel_err,
  output logic                disp_fail,
  output logic                busy
);
  localparam int IW = $clog2(IDLE_TMO + 1);
  localparam int DW = $clog2(DISP_TMO + 1);
  typedef logic [CREDIT_W:0] wide_t;
  localparam wide_t CMAX = {1'b0, {CREDIT_W{1'b1}}};
  state_t st, st_n;
  logic [7:0] sel_q, item_n, out_n;
  logic [IW-1:0] idle_cnt, idle_n;
  logic [DW-1:0] disp_cnt, dcnt_n;
  logic [2:0] price_q, price_n;
  logic [CREDIT_W-1:0] credit_n, pay_rem;
  logic [1:0] chg_n, pay_chg;
  logic req_n, rej_n, serr_n, fail_n, pay_done;
  wide_t coin_amt, credit_c, price;
  logic coin_ok, sel_edge, sel_ok, quiet;

  vend_change_seq #(.CREDIT_W(CREDIT_W)) u_pay (
    .start(st == ST_PAYOUT),
    .load(credit),
    .change(pay_chg),
    .done(pay_done),
    .rem(pay_rem)
  );

  always_comb begin
    coin_amt = money == COIN_5 ? wide_t'(1) : money == COIN_10 ? wide_t'(2) : '0;
    coin_ok = coin_amt != '0 && wide_t'(credit) + coin_amt <= CMAX;
    // selections and cancel see the coin accepted in the same cycle
    credit_c = wide_t'(credit) + (coin_ok ? coin_amt : '0);
    price = wide_t'(price_of(sel_item));
    sel_edge = sel_q == 8'd0 && sel_item != 8'd0;
    sel_ok = price != '0 && credit_c >= price;
    quiet = credit != '0 && money == COIN_NONE && !sel_edge && !cancel;
    st_n = st;
    credit_n = credit;
    req_n = disp_req;
    item_n = disp_item;
    out_n = '0;
    chg_n = CHG_NONE;
    rej_n = money != COIN_NONE;
    serr_n = 1'b0;
    fail_n = 1'b0;
    idle_n = '0;
    dcnt_n = '0;
    price_n = price_q;
    case (st)
      ST_IDLE: begin
        rej_n = money != COIN_NONE && !coin_ok;
        credit_n = credit_c[CREDIT_W-1:0];
        if (cancel && credit_c != '0) st_n = ST_PAYOUT;
        else if (sel_edge && sel_ok) begin
          credit_n = CREDIT_W'(credit_c - price);
          st_n = ST_DISPENSE;
          req_n = 1'b1;
          item_n = sel_item;
          price_n = price_of(sel_item);
        end else if (sel_edge) serr_n = 1'b1;
        else if (quiet) begin
          if (idle_cnt == IW'(IDLE_TMO - 1)) st_n = ST_PAYOUT;
          else idle_n = idle_cnt + 1'b1;
        end
      end
      ST_DISPENSE: begin
        if (disp_ack) begin
          out_n = disp_item;
          req_n = 1'b0;
          item_n = '0;
          st_n = credit != '0 ? ST_PAYOUT : ST_IDLE;
        end else if (disp_cnt == DW'(DISP_TMO - 1)) begin
          // aborted dispense: the item was never released, so refund its price
          credit_n = credit + CREDIT_W'(price_q);
          fail_n = 1'b1;
          req_n = 1'b0;
          item_n = '0;
          st_n = ST_PAYOUT;
        end else dcnt_n = disp_cnt + 1'b1;
      end
      default: begin
        credit_n = pay_rem;
        chg_n = pay_chg;
        if (pay_done) st_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      st <= ST_IDLE;
      sel_q <= '0;
      idle_cnt <= '0;
      disp_cnt <= '0;
      price_q <= '0;
      credit <= '0;
      disp_req <= 1'b0;
      disp_item <= '0;
      item_out <= '0;
      change <= CHG_NONE;
      coin_rej <= 1'b0;
      sel_err <= 1'b0;
      disp_fail <= 1'b0;
      busy <= 1'b0;
    end else begin
      st <= st_n;
      sel_q <= sel_item;
      idle_cnt <= idle_n;
      disp_cnt <= dcnt_n;
      price_q <= price_n;
      credit <= credit_n;
      disp_req <= req_n;
      disp_item <= item_n;
      item_out <= out_n;
      change <= chg_n;
      coin_rej <= rej_n;
      sel_err <= serr_n;
      disp_fail <= fail_n;
      busy <= st_n != ST_IDLE;
    end

  // a credit decrement must never wrap around to a larger value
  assert property (@(posedge clk) disable iff (!reset)
    (st != ST_PAYOUT || pay_rem <= credit) && (st != ST_IDLE || st_n != ST_DISPENSE || wide_t'(credit_n) <= credit_c));
endmodule
